ext_mem_loader: RTL and testbench

//  Boot loader that drives the CPU's external instruction/data memory load ports.

---
 rtl/ext_mem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_ext_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_loader.sv
// Boot loader: streams IMEM words, then DMEM words, into the CPU external load ports, then enables the CPU.
// Optional feature macro CHECKSUM_EN adds a trailing checksum beat (CHK state) and a locked ERR state.
module ext_mem_loader #(
   parameter int          CNT_W     = 10,
   parameter logic [63:0] IMEM_BASE = 64'd0,
   parameter logic [63:0] DMEM_BASE = 64'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] imem_words,
   input  logic [CNT_W-1:0] dmem_words,
   input  logic             in_valid,
   input  logic [63:0]      in_data,
   output logic             in_ready,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   output logic             cpu_enable,
   output logic             busy,
   output logic             err
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_I = 3'd1;
   localparam logic [2:0] ST_LOAD_D = 3'd2;
   localparam logic [2:0] ST_CHK    = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

`ifdef CHECKSUM_EN
   localparam logic [2:0] ST_AFTER_LOAD = ST_CHK;
`else
   localparam logic [2:0] ST_AFTER_LOAD = ST_RUN;
`endif

   logic [2:0]       state_r;
   logic [2:0]       state_next_s;
   logic [CNT_W-1:0] imem_cnt_r;
   logic [CNT_W-1:0] dmem_cnt_r;
   logic [CNT_W-1:0] idx_r;
   logic             fire_s;
   logic             last_i_s;
   logic             last_d_s;
   logic             load_next_s;
   logic             chk_ok_s;
   logic [63:0]      imem_addr_s;
   logic [63:0]      dmem_addr_s;

`ifdef CHECKSUM_EN
   logic [63:0]      sum_r;
`endif

   assign ren_ext     = 1'b0;
   assign ren_ext_2   = 1'b0;
   assign fire_s      = in_valid & in_ready;
   assign last_i_s    = (idx_r == (imem_cnt_r - CNT_W'(1)));
   assign last_d_s    = (idx_r == (dmem_cnt_r - CNT_W'(1)));
   assign imem_addr_s = IMEM_BASE + {{(62-CNT_W){1'b0}}, idx_r, 2'b00};
   assign dmem_addr_s = DMEM_BASE + {{(61-CNT_W){1'b0}}, idx_r, 3'b000};
   assign load_next_s = (state_next_s == ST_LOAD_I) || (state_next_s == ST_LOAD_D) ||
                        (state_next_s == ST_CHK);

`ifdef CHECKSUM_EN
   assign chk_ok_s = (in_data == sum_r);
`else
   assign chk_ok_s = 1'b0;
`endif

   // Next-state decode; an empty memory region is skipped without a bubble.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (imem_words != {CNT_W{1'b0}}) begin
                  state_next_s = ST_LOAD_I;
               end else if (dmem_words != {CNT_W{1'b0}}) begin
                  state_next_s = ST_LOAD_D;
               end else begin
                  state_next_s = ST_AFTER_LOAD;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD_I: begin
            if (fire_s && last_i_s) begin
               if (dmem_cnt_r != {CNT_W{1'b0}}) begin
                  state_next_s = ST_LOAD_D;
               end else begin
                  state_next_s = ST_AFTER_LOAD;
               end
            end else begin
               state_next_s = ST_LOAD_I;
            end
         end
         ST_LOAD_D: begin
            if (fire_s && last_d_s) begin
               state_next_s = ST_AFTER_LOAD;
            end else begin
               state_next_s = ST_LOAD_D;
            end
         end
         ST_CHK: begin
            if (fire_s) begin
               state_next_s = chk_ok_s ? ST_RUN : ST_ERR;
            end else begin
               state_next_s = ST_CHK;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_ERR: begin
`ifdef CHECKSUM_EN
            state_next_s = ST_ERR;
`else
            state_next_s = ST_IDLE;
`endif
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered memory-port outputs; addresses/data hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         imem_cnt_r  <= {CNT_W{1'b0}};
         dmem_cnt_r  <= {CNT_W{1'b0}};
         idx_r       <= {CNT_W{1'b0}};
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         cpu_enable  <= 1'b0;
         addr_ext    <= 64'd0;
         wen_ext     <= 1'b0;
         wdata_ext   <= 32'd0;
         addr_ext_2  <= 64'd0;
         wen_ext_2   <= 1'b0;
         wdata_ext_2 <= 64'd0;
      end else begin
         state_r    <= state_next_s;
         in_ready   <= load_next_s;
         busy       <= load_next_s;
         cpu_enable <= (state_next_s == ST_RUN);
         wen_ext    <= 1'b0;
         wen_ext_2  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  imem_cnt_r <= imem_words;
                  dmem_cnt_r <= dmem_words;
                  idx_r      <= {CNT_W{1'b0}};
               end
            end
            ST_LOAD_I: begin
               if (fire_s) begin
                  wen_ext   <= 1'b1;
                  addr_ext  <= imem_addr_s;
                  wdata_ext <= in_data[31:0];
                  idx_r     <= last_i_s ? {CNT_W{1'b0}} : (idx_r + CNT_W'(1));
               end
            end
            ST_LOAD_D: begin
               if (fire_s) begin
                  wen_ext_2   <= 1'b1;
                  addr_ext_2  <= dmem_addr_s;
                  wdata_ext_2 <= in_data;
                  idx_r       <= last_d_s ? {CNT_W{1'b0}} : (idx_r + CNT_W'(1));
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

`ifdef CHECKSUM_EN
   // Running modulo-2^64 sum of written words; err mirrors the locked ERR state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_r <= 64'd0;
         err   <= 1'b0;
      end else begin
         err <= (state_next_s == ST_ERR);
         if ((state_r == ST_IDLE) && start) begin
            sum_r <= 64'd0;
         end else if (fire_s && (state_r == ST_LOAD_I)) begin
            sum_r <= sum_r + {32'd0, in_data[31:0]};
         end else if (fire_s && (state_r == ST_LOAD_D)) begin
            sum_r <= sum_r + in_data;
         end else begin
            sum_r <= sum_r;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: a per-cycle vector table plus hand-written reset and checksum sequences.
module tb_ext_mem_loader;

   localparam logic [63:0] BIG = 64'h1122334455667788;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [9:0]  imem_words;
   logic [9:0]  dmem_words;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst;
      logic        start;
      logic        stop;
      logic [9:0]  iw;
      logic [9:0]  dw;
      logic        v;
      logic [63:0] d;
      logic        e_ready;
      logic        e_wen;
      logic [63:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_wen2;
      logic [63:0] e_addr2;
      logic [63:0] e_wdata2;
      logic        e_cpu;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   ext_mem_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .imem_words  (imem_words),
      .dmem_words  (dmem_words),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed snapshot: ready, wen, addr, wdata, wen2, addr2, wdata2, cpu, busy, err, ren, ren2.
   function automatic logic [231:0] outs();
      return {in_ready, wen_ext, addr_ext, wdata_ext, wen_ext_2, addr_ext_2, wdata_ext_2,
              cpu_enable, busy, err, ren_ext, ren_ext_2};
   endfunction

   task automatic check(input string name, input logic [231:0] act, input logic [231:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic p, input logic [9:0] iw,
                        input logic [9:0] dw, input logic v, input logic [63:0] d);
      rst = r; start = s; stop = p; imem_words = iw; dmem_words = dw; in_valid = v; in_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic s, input logic p, input logic [9:0] iw,
                      input logic [9:0] dw, input logic v, input logic [63:0] d,
                      input logic er, input logic ew, input logic [63:0] ea, input logic [31:0] ed,
                      input logic ew2, input logic [63:0] ea2, input logic [63:0] ed2,
                      input logic ec, input logic eb);
      vec_t t;
      t.rst = r; t.start = s; t.stop = p; t.iw = iw; t.dw = dw; t.v = v; t.d = d;
      t.e_ready = er; t.e_wen = ew; t.e_addr = ea; t.e_wdata = ed;
      t.e_wen2 = ew2; t.e_addr2 = ea2; t.e_wdata2 = ed2; t.e_cpu = ec; t.e_busy = eb;
      vecs.push_back(t);
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0);
      #2;

`ifndef CHECKSUM_EN
      // Each row: inputs applied before an edge, outputs expected just after it.
      add(1,0,0, 0,0, 0,64'd0,      0,0,64'd0,32'd0,    0,64'd0,64'd0, 0,0);
      add(1,0,0, 0,0, 0,64'd0,      0,0,64'd0,32'd0,    0,64'd0,64'd0, 0,0);
      add(1,0,0, 0,0, 0,64'd0,      0,0,64'd0,32'd0,    0,64'd0,64'd0, 0,0);
      add(0,1,0, 2,1, 0,64'd0,      1,0,64'd0,32'd0,    0,64'd0,64'd0, 0,1);
      add(0,0,0, 0,0, 1,64'h13,     1,1,64'd0,32'h13,   0,64'd0,64'd0, 0,1);
      add(0,0,0, 0,0, 1,64'h93,     1,1,64'd4,32'h93,   0,64'd0,64'd0, 0,1);
      add(0,0,0, 0,0, 1,BIG,        0,0,64'd4,32'h93,   1,64'd0,BIG,   1,0);
      add(0,0,0, 0,0, 0,64'd0,      0,0,64'd4,32'h93,   0,64'd0,BIG,   1,0);
      add(0,0,1, 0,0, 0,64'd0,      0,0,64'd4,32'h93,   0,64'd0,BIG,   0,0);
      add(0,1,0, 0,0, 1,64'hEE,     0,0,64'd4,32'h93,   0,64'd0,BIG,   1,0);
      add(0,1,1, 0,0, 0,64'd0,      0,0,64'd4,32'h93,   0,64'd0,BIG,   0,0);
      add(0,0,0, 0,0, 0,64'd0,      0,0,64'd4,32'h93,   0,64'd0,BIG,   0,0);
      add(0,1,0, 2,0, 0,64'd0,      1,0,64'd4,32'h93,   0,64'd0,BIG,   0,1);
      add(0,0,0, 0,0, 1,64'hA,      1,1,64'd0,32'hA,    0,64'd0,BIG,   0,1);
      add(0,1,0, 5,0, 0,64'd0,      1,0,64'd0,32'hA,    0,64'd0,BIG,   0,1);
      add(0,0,0, 0,0, 1,64'hB,      0,1,64'd4,32'hB,    0,64'd0,BIG,   1,0);
      add(0,0,0, 0,0, 0,64'd0,      0,0,64'd4,32'hB,    0,64'd0,BIG,   1,0);
      add(0,0,1, 0,0, 0,64'd0,      0,0,64'd4,32'hB,    0,64'd0,BIG,   0,0);
      add(0,1,0, 0,2, 0,64'd0,      1,0,64'd4,32'hB,    0,64'd0,BIG,   0,1);
      add(0,0,0, 0,0, 1,64'hC1,     1,0,64'd4,32'hB,    1,64'd0,64'hC1, 0,1);
      add(0,0,0, 0,0, 0,64'd0,      1,0,64'd4,32'hB,    0,64'd0,64'hC1, 0,1);
      add(0,0,0, 0,0, 1,64'hC2,     0,0,64'd4,32'hB,    1,64'd8,64'hC2, 1,0);
      add(0,0,1, 0,0, 0,64'd0,      0,0,64'd4,32'hB,    0,64'd8,64'hC2, 0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].iw, vecs[i].dw,
               vecs[i].v, vecs[i].d);
         tick();
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].e_ready, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_wdata,
                vecs[i].e_wen2, vecs[i].e_addr2, vecs[i].e_wdata2,
                vecs[i].e_cpu, vecs[i].e_busy, 1'b0, 1'b0, 1'b0});
      end
`endif

      // Reset in the middle of an IMEM load, then reload from the base address.
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0); tick();
      drive(1'b0, 1'b1, 1'b0, 10'd3, 10'd0, 1'b0, 64'd0); tick();
      check("mid_start_ready", 232'({in_ready, busy}), 232'(2'b11));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'hAA); tick();
      check("mid_first_write", 232'({wen_ext, addr_ext, wdata_ext}), 232'({1'b1, 64'd0, 32'hAA}));
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'hAB); tick();
      check("mid_reset_zero", outs(), 232'd0);
      drive(1'b0, 1'b1, 1'b0, 10'd3, 10'd0, 1'b0, 64'd0); tick();
      check("reload_ready", 232'({in_ready, busy, wen_ext}), 232'(3'b110));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'hBB); tick();
      check("reload_addr0", 232'({wen_ext, addr_ext, wdata_ext}), 232'({1'b1, 64'd0, 32'hBB}));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'hCC); tick();
      check("reload_addr4", 232'({wen_ext, addr_ext, wdata_ext}), 232'({1'b1, 64'd4, 32'hCC}));

`ifdef CHECKSUM_EN
      // Checksum 5+7=12 accepted.
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0); tick();
      drive(1'b0, 1'b1, 1'b0, 10'd1, 10'd1, 1'b0, 64'd0); tick();
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd5); tick();
      check("ck_imem", 232'({wen_ext, addr_ext, wdata_ext}), 232'({1'b1, 64'd0, 32'd5}));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd7); tick();
      check("ck_dmem", 232'({wen_ext_2, addr_ext_2, wdata_ext_2}), 232'({1'b1, 64'd0, 64'd7}));
      check("ck_in_chk", 232'({in_ready, busy, cpu_enable, err}), 232'(4'b1100));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd12); tick();
      check("ck_match", 232'({in_ready, busy, cpu_enable, err}), 232'(4'b0010));
      // Checksum 13 mismatches and locks up in ERR.
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0); tick();
      drive(1'b0, 1'b1, 1'b0, 10'd1, 10'd1, 1'b0, 64'd0); tick();
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd5); tick();
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd7); tick();
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd13); tick();
      check("ck_mismatch", 232'({in_ready, busy, cpu_enable, err}), 232'(4'b0001));
      drive(1'b0, 1'b1, 1'b0, 10'd1, 10'd1, 1'b1, 64'd0); tick();
      check("ck_err_sticky", 232'({in_ready, busy, cpu_enable, err}), 232'(4'b0001));
      // Empty load still expects a zero checksum beat.
      drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0); tick();
      check("ck_rst_clear", outs(), 232'd0);
      drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 64'd0); tick();
      check("ck_empty_chk", 232'({in_ready, busy, cpu_enable}), 232'(3'b110));
      drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 64'd0); tick();
      check("ck_empty_run", 232'({in_ready, busy, cpu_enable, err}), 232'(4'b0010));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
